// File: rtl/xgriscv_imem_loader_pkg.sv
// Shared types and defaults for the imem boot loader: FSM states, sync marker, address width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xgriscv_imem_loader_pkg;

    localparam int unsigned LDR_IMEM_AW = 8;
    localparam logic [7:0]  LDR_SYNC    = 8'hA5;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_LEN0,
        LDR_LEN1,
        LDR_DATA,
        LDR_CSUM,
        LDR_DONE,
        LDR_ERR
    } ldr_state_t;

    // A frame may fill the whole memory but never exceed it.
    function automatic logic len_overflow(input logic [15:0] n_words, input int unsigned aw);
        return {1'b0, n_words} > (17'd1 << aw);
    endfunction

endpackage

// File: rtl/xgriscv_imem_loader_if.sv
// Loader bus bundle: host byte link, imem write port, core reset/status (+ echo link with IMEM_LOADER_ECHO_EN).
// Latency: n/a (wires only).
// Backpressure: master (loader) drives rx_ready; slave (host side) drives tx_ready when echo is built.
interface xgriscv_imem_loader_if
    import xgriscv_imem_loader_pkg::*;
#(
    parameter int unsigned IMEM_AW = LDR_IMEM_AW
);
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               rx_ready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               core_rstn;
    logic               load_done;
    logic               load_err;
`ifdef IMEM_LOADER_ECHO_EN
    logic               tx_valid;
    logic [7:0]         tx_data;
    logic               tx_ready;
`endif

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, core_rstn, load_done, load_err
`ifdef IMEM_LOADER_ECHO_EN
        , output tx_valid, tx_data
        , input  tx_ready
`endif
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, core_rstn, load_done, load_err
`ifdef IMEM_LOADER_ECHO_EN
        , input  tx_valid, tx_data
        , output tx_ready
`endif
    );

endinterface

// File: rtl/xgriscv_imem_loader_byte_packer.sv
// Packs data bytes LSB-first into 32-bit words and keeps the running XOR of all data bytes.
// Latency: word_rdy/word_dat are combinational with the 4th byte of a word.
// Backpressure: none; consumes a byte whenever byte_vld is high.
module xgriscv_imem_loader_byte_packer
    import xgriscv_imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        word_rdy,
    output logic [31:0] word_dat,
    output logic [7:0]  csum
);

    logic [1:0]  idx_q;
    logic [23:0] sh_q;
    logic [7:0]  csum_q;

    // After three shifts sh_q holds {b2, b1, b0}; the 4th byte completes the word on the wire.
    assign word_rdy = byte_vld && (idx_q == 2'd3);
    assign word_dat = {byte_dat, sh_q};
    assign csum     = csum_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q  <= 2'd0;
            sh_q   <= 24'd0;
            csum_q <= 8'd0;
        end else if (clear) begin
            idx_q  <= 2'd0;
            sh_q   <= 24'd0;
            csum_q <= 8'd0;
        end else if (byte_vld) begin
            idx_q  <= idx_q + 2'd1;
            sh_q   <= {byte_dat, sh_q[23:8]};
            csum_q <= csum_q ^ byte_dat;
        end
    end

endmodule

// File: rtl/xgriscv_imem_loader.sv
// Boot loader: framed byte stream -> imem words; releases core reset after a checksum-valid image.
// Latency: imem write one cycle after a word's 4th byte; core_rstn rises one cycle after load_done.
// Backpressure: rx_ready high after reset; with IMEM_LOADER_ECHO_EN it drops while an echo is pending.
module xgriscv_imem_loader
    import xgriscv_imem_loader_pkg::*;
#(
    parameter int unsigned IMEM_AW   = LDR_IMEM_AW,
    parameter logic [7:0]  SYNC_BYTE = LDR_SYNC
)(
    input  logic                  clk,
    input  logic                  rstn,
    xgriscv_imem_loader_if.master bus
);

    ldr_state_t         state_q, state_d;
    logic               rdy_q;
    logic               rx_ready;
    logic               accept;
    logic               is_sync;
    logic [7:0]         len_lo_q;
    logic [15:0]        len_q;
    logic [15:0]        word_cnt_q;
    logic [15:0]        n_words;
    logic               last_word;
    logic               we_q;
    logic [IMEM_AW-1:0] addr_q;
    logic [31:0]        wdata_q;
    logic               core_rstn_q;

    logic               pk_clear;
    logic               pk_vld;
    logic               pk_word_rdy;
    logic [31:0]        pk_word;
    logic [7:0]         pk_csum;

    assign accept    = bus.rx_valid && rx_ready;
    assign is_sync   = accept && (bus.rx_data == SYNC_BYTE);
    assign n_words   = {bus.rx_data, len_lo_q};
    assign last_word = (word_cnt_q == len_q - 16'd1);
    assign pk_clear  = is_sync && (state_q inside {LDR_IDLE, LDR_DONE, LDR_ERR});
    assign pk_vld    = accept && (state_q == LDR_DATA);

    xgriscv_imem_loader_byte_packer u_packer (
        .clk      (clk),
        .rstn     (rstn),
        .clear    (pk_clear),
        .byte_vld (pk_vld),
        .byte_dat (bus.rx_data),
        .word_rdy (pk_word_rdy),
        .word_dat (pk_word),
        .csum     (pk_csum)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LDR_IDLE, LDR_DONE, LDR_ERR: begin
                if (is_sync) state_d = LDR_LEN0;
            end
            LDR_LEN0: begin
                if (accept) state_d = LDR_LEN1;
            end
            LDR_LEN1: begin
                if (accept) begin
                    if (len_overflow(n_words, IMEM_AW)) state_d = LDR_ERR;
                    else if (n_words == 16'd0)          state_d = LDR_CSUM;
                    else                                state_d = LDR_DATA;
                end
            end
            LDR_DATA: begin
                if (pk_word_rdy && last_word) state_d = LDR_CSUM;
            end
            LDR_CSUM: begin
                if (accept) state_d = (bus.rx_data == pk_csum) ? LDR_DONE : LDR_ERR;
            end
            default: state_d = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= LDR_IDLE;
            rdy_q       <= 1'b0;
            len_lo_q    <= 8'd0;
            len_q       <= 16'd0;
            word_cnt_q  <= 16'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            core_rstn_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            we_q    <= pk_word_rdy;
            // The core only leaves reset once DONE has been visible for a full cycle.
            core_rstn_q <= (state_q == LDR_DONE) && !is_sync;
            if (accept && state_q == LDR_LEN0) len_lo_q <= bus.rx_data;
            if (accept && state_q == LDR_LEN1) len_q    <= n_words;
            if (pk_clear) begin
                word_cnt_q <= 16'd0;
            end else if (pk_word_rdy) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
            if (pk_word_rdy) begin
                addr_q  <= word_cnt_q[IMEM_AW-1:0];
                wdata_q <= pk_word;
            end
        end
    end

`ifdef IMEM_LOADER_ECHO_EN
    logic       tx_vld_q;
    logic [7:0] tx_dat_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_vld_q <= 1'b0;
            tx_dat_q <= 8'd0;
        end else if (accept) begin
            tx_vld_q <= 1'b1;
            tx_dat_q <= bus.rx_data;
        end else if (bus.tx_ready) begin
            tx_vld_q <= 1'b0;
        end
    end

    // One echo slot: no new byte is taken until the previous echo has left.
    assign rx_ready    = rdy_q && !tx_vld_q;
    assign bus.tx_valid = tx_vld_q;
    assign bus.tx_data  = tx_dat_q;
`else
    assign rx_ready = rdy_q;
`endif

    assign bus.rx_ready   = rx_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.core_rstn  = core_rstn_q;
    assign bus.load_done  = (state_q == LDR_DONE);
    assign bus.load_err   = (state_q == LDR_ERR);

endmodule

// File: tb/tb_xgriscv_imem_loader.sv
// Randomized frame stimulus against a frame-level reference model of the imem boot loader.
module tb_xgriscv_imem_loader;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [7:0]  SYNC  = 8'hA5;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    xgriscv_imem_loader_if #(.IMEM_AW(AW)) bus ();

    xgriscv_imem_loader #(.IMEM_AW(AW), .SYNC_BYTE(SYNC)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] shadow  [DEPTH];
    logic [31:0] exp_mem [DEPTH];
    bit          exp_v   [DEPTH];
    int          wr_cnt     = 0;
    int          exp_wr_cnt = 0;
    logic        prev_we    = 1'b0;
    bit          exp_done   = 1'b0;
    bit          exp_err    = 1'b0;
    logic [7:0]  echo_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.imem_we) begin
            check("we_back_to_back", {31'd0, prev_we}, 32'd0);
            shadow[bus.imem_addr] = bus.imem_wdata;
            wr_cnt++;
        end
        prev_we = bus.imem_we;
    end

`ifdef IMEM_LOADER_ECHO_EN
    always @(negedge clk) begin
        if (bus.tx_valid && bus.tx_ready) begin
            if (echo_q.size() == 0) check("echo_extra", 32'(echo_q.size()), 32'd1);
            else                    check("echo_byte", {24'd0, bus.tx_data}, {24'd0, echo_q.pop_front()});
        end
    end
`endif

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        repeat ($urandom_range(0, 1)) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t = 0;
        while (!bus.rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("rx_ready_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
`ifdef IMEM_LOADER_ECHO_EN
        echo_q.push_back(b);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"},   {31'd0, bus.rx_ready}, 32'd0);
        check({tag, "_imem_we"},    {31'd0, bus.imem_we}, 32'd0);
        check({tag, "_imem_addr"},  32'(bus.imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
        check({tag, "_core_rstn"},  {31'd0, bus.core_rstn}, 32'd0);
        check({tag, "_load_done"},  {31'd0, bus.load_done}, 32'd0);
        check({tag, "_load_err"},   {31'd0, bus.load_err}, 32'd0);
`ifdef IMEM_LOADER_ECHO_EN
        check({tag, "_tx_valid"},   {31'd0, bus.tx_valid}, 32'd0);
        check({tag, "_tx_data"},    {24'd0, bus.tx_data}, 32'd0);
`endif
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        #2;
        check_reset_outputs(tag);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        check({tag, "_rdy_first_cycle"}, {31'd0, bus.rx_ready}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_rdy_after"}, {31'd0, bus.rx_ready}, 32'd1);
        exp_done = 1'b0;
        exp_err  = 1'b0;
    endtask

    // Reference: a frame of n words either overflows at the length, or writes all n words
    // and then ends in DONE or ERR depending on the XOR of the data bytes.
    task automatic run_frame(input int n, input bit bad_csum, input int n_garbage,
                             input bit use_w0, input logic [31:0] w0);
        logic [7:0]  b;
        logic [7:0]  cs;
        logic [31:0] w;
        logic [15:0] n16;
        for (int g = 0; g < n_garbage; g++) begin
            b = 8'($urandom_range(0, 255));
            if (b == SYNC) b = 8'h5A;
            send_byte(b);
        end
        if (n_garbage > 0) begin
            check("garbage_keeps_done", {31'd0, bus.load_done}, {31'd0, exp_done});
            check("garbage_keeps_err",  {31'd0, bus.load_err},  {31'd0, exp_err});
        end
        send_byte(SYNC);
        check("sync_done_low",  {31'd0, bus.load_done}, 32'd0);
        check("sync_core_low",  {31'd0, bus.core_rstn}, 32'd0);
        check("sync_err_clear", {31'd0, bus.load_err},  32'd0);
        n16 = 16'(n);
        send_byte(n16[7:0]);
        send_byte(n16[15:8]);
        if (n > int'(DEPTH)) begin
            check("len_ovf_err",   {31'd0, bus.load_err},  32'd1);
            check("len_ovf_done",  {31'd0, bus.load_done}, 32'd0);
            check("len_ovf_nowr",  32'(wr_cnt), 32'(exp_wr_cnt));
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        cs = 8'd0;
        for (int i = 0; i < n; i++) begin
            w = (use_w0 && i == 0) ? w0 : $urandom;
            for (int k = 0; k < 4; k++) begin
                b  = w[8*k +: 8];
                cs = cs ^ b;
                send_byte(b);
            end
            check("wr_strobe", {31'd0, bus.imem_we}, 32'd1);
            check("wr_addr",   32'(bus.imem_addr), 32'(i));
            check("wr_data",   bus.imem_wdata, w);
            exp_mem[i] = w;
            exp_v[i]   = 1'b1;
            exp_wr_cnt++;
        end
        if (bad_csum) cs = cs ^ 8'($urandom_range(1, 255));
        send_byte(cs);
        check("end_done", {31'd0, bus.load_done}, {31'd0, !bad_csum});
        check("end_err",  {31'd0, bus.load_err},  {31'd0, bad_csum});
        check("end_core_same_cycle", {31'd0, bus.core_rstn}, 32'd0);
        @(posedge clk);
        #1;
        check("end_core_next_cycle", {31'd0, bus.core_rstn}, {31'd0, !bad_csum});
        check("wr_count", 32'(wr_cnt), 32'(exp_wr_cnt));
        exp_done = !bad_csum;
        exp_err  = bad_csum;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
`ifdef IMEM_LOADER_ECHO_EN
        bus.tx_ready = 1'b1;
`endif
        #1;
        do_reset("por");

        // Single known word, then a two-word frame with a bad checksum.
        run_frame(1, 1'b0, 0, 1'b1, 32'h00A0_0513);
        run_frame(2, 1'b1, 1, 1'b0, 32'd0);
        // Length one past the memory depth, then an empty image, then a reload from DONE.
        run_frame(257, 1'b0, 0, 1'b0, 32'd0);
        run_frame(0, 1'b0, 2, 1'b0, 32'd0);
        run_frame(1, 1'b0, 3, 1'b0, 32'd0);

        // Reset in the middle of a data word.
        send_byte(SYNC);
        send_byte(8'h04);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (2) @(posedge clk);
        #1;
        do_reset("midframe");
        run_frame(3, 1'b0, 0, 1'b0, 32'd0);

        for (int f = 0; f < 8; f++) begin
            run_frame($urandom_range(1, 6), ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 2), 1'b0, 32'd0);
        end
        run_frame(256, 1'b0, 1, 1'b0, 32'd0);
        run_frame(65535, 1'b0, 0, 1'b0, 32'd0);
        run_frame(2, 1'b0, 0, 1'b0, 32'd0);

`ifdef IMEM_LOADER_ECHO_EN
        bus.tx_ready = 1'b0;
        send_byte(8'h3C);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("echo_stall_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
            check("echo_stall_tx_valid", {31'd0, bus.tx_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        bus.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("echo_all_seen", 32'(echo_q.size()), 32'd0);
`endif

        repeat (3) @(posedge clk);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (exp_v[i]) check("mem_image", shadow[i], exp_mem[i]);
        end
        check("total_writes", 32'(wr_cnt), 32'(exp_wr_cnt));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
